// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU opcode sequencer.
package alu_seq_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;
  localparam int ERR_W  = 16;

  typedef enum logic [2:0] {
    OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD, OP_SHL, OP_SHR, OP_TRUNC
  } aluOpT;

  typedef enum logic [1:0] {
    IDLE, DRIVE, WAIT
  } seqStateT;
endpackage

// File: rtl/alu_op_sequencer_ref.sv
// Combinational golden model of the 32-bit ALU, used by the optional self-check.
module alu32_ref_model
  import alu_seq_pkg::*;
(
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  input  logic              carryIn,
  input  logic [2:0]        opSel,
  output logic [DATA_W-1:0] result,
  output logic              carryOut
);
  logic [DATA_W:0] sum;

  always_comb begin
    sum      = {1'b0, opA} + {1'b0, opB} + {{DATA_W{1'b0}}, carryIn};
    result   = '0;
    carryOut = 1'b0;
    case (aluOpT'(opSel))
      OP_AND:   result = opA & opB;
      OP_OR:    result = opA | opB;
      OP_XOR:   result = opA ^ opB;
      OP_NOT:   result = ~opA;
      OP_ADD:   {carryOut, result} = sum;
      OP_SHL:   result = opA << opB[4:0];
      OP_SHR:   result = opA >> opB[4:0];
      OP_TRUNC: result = {16'h0, opA[15:0]};
    endcase
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// Walks one latched operand set through all 8 ALU opcodes, holding each for HOLD cycles.
// Define ALU_SEQ_CHECK_EN to compare every captured result against alu32_ref_model.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int HOLD = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_ci,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic        alu_ci,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic        alu_co,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [2:0]  res_op,
  output logic [31:0] res_data,
  output logic        res_co,
  output logic        busy,
  output logic        done,
  output logic        err_sticky,
  output logic [15:0] err_count
);
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD - 1);

  seqStateT         state, stateNext;
  logic [CNT_W-1:0] cnt;
  logic             accept, capture, resHandshake, lastOp;

  assign accept       = (state == IDLE) && in_valid;
  assign capture      = (state == DRIVE) && (cnt == '0);
  assign resHandshake = (state == WAIT) && res_ready;
  assign lastOp       = (aluOpT'(alu_op) == OP_TRUNC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) stateNext = DRIVE;
      end
      DRIVE: if (cnt == '0) stateNext = WAIT;
      WAIT: begin
        res_valid = 1'b1;
        if (res_ready) stateNext = lastOp ? IDLE : DRIVE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_in1  <= '0;
      alu_in2  <= '0;
      alu_ci   <= 1'b0;
      alu_op   <= '0;
      cnt      <= '0;
      res_op   <= '0;
      res_data <= '0;
      res_co   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        alu_in1 <= in_a;
        alu_in2 <= in_b;
        alu_ci  <= in_ci;
        alu_op  <= OP_AND;
        cnt     <= HOLD_RELOAD;
      end
      if (capture) begin
        res_op   <= alu_op;
        res_data <= alu_out;
        res_co   <= alu_co;
      end else if (state == DRIVE) begin
        cnt <= cnt - 1'b1;
      end
      // Last opcode ends the set; otherwise step to the next opcode and re-arm the hold
      if (resHandshake) begin
        if (lastOp) begin
          done <= 1'b1;
        end else begin
          alu_op <= alu_op + 3'd1;
          cnt    <= HOLD_RELOAD;
        end
      end
    end
  end

`ifdef ALU_SEQ_CHECK_EN
  logic [31:0]      refOut;
  logic             refCo;
  logic             mismatch;
  logic             errStickyR;
  logic [ERR_W-1:0] errCountR;

  function automatic logic [ERR_W-1:0] satInc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  alu32_ref_model uRef (
    .opA      (alu_in1),
    .opB      (alu_in2),
    .carryIn  (alu_ci),
    .opSel    (alu_op),
    .result   (refOut),
    .carryOut (refCo)
  );

  // Carry is only architecturally meaningful for ADD, so it is only compared there
  assign mismatch = capture &&
                    ((alu_out != refOut) || ((aluOpT'(alu_op) == OP_ADD) && (alu_co != refCo)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errStickyR <= 1'b0;
      errCountR  <= '0;
    end else if (mismatch) begin
      errStickyR <= 1'b1;
      errCountR  <= satInc(errCountR);
    end
  end

  assign err_sticky = errStickyR;
  assign err_count  = errCountR;
`else
  assign err_sticky = 1'b0;
  assign err_count  = '0;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer with a behavioural ALU and result model.
module tb_alu_op_sequencer;
  localparam int HOLD = 2;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic        in_valid = 1'b0, in_ready, in_ci = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic [31:0] alu_in1, alu_in2, alu_out, res_data;
  logic        alu_ci, alu_co, res_valid, res_ready = 1'b1, res_co;
  logic [2:0]  alu_op, res_op;
  logic        busy, done, err_sticky;
  logic [15:0] err_count;

  int          checks = 0, errors = 0;
  logic        faultOn = 1'b0;
  logic [31:0] got [8];
  logic [32:0] aluRes;

  always #5 clk = ~clk;

  alu_op_sequencer #(.HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ci(alu_ci), .alu_op(alu_op),
    .alu_out(alu_out), .alu_co(alu_co),
    .res_valid(res_valid), .res_ready(res_ready), .res_op(res_op),
    .res_data(res_data), .res_co(res_co),
    .busy(busy), .done(done), .err_sticky(err_sticky), .err_count(err_count)
  );

  // Behavioural ALU: {carry, result}
  function automatic logic [32:0] aluFn(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic ci);
    case (op)
      3'd0: return {1'b0, a & b};
      3'd1: return {1'b0, a | b};
      3'd2: return {1'b0, a ^ b};
      3'd3: return {1'b0, ~a};
      3'd4: return {1'b0, a} + {1'b0, b} + {32'h0, ci};
      3'd5: return {1'b0, a << b[4:0]};
      3'd6: return {1'b0, a >> b[4:0]};
      default: return {17'h0, a[15:0]};
    endcase
  endfunction

  assign aluRes  = aluFn(alu_op, alu_in1, alu_in2, alu_ci);
  assign alu_out = aluRes[31:0] ^ {31'h0, faultOn && (alu_op == 3'd1)};
  assign alu_co  = aluRes[32];

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkResetState();
    checkEq("rstResValid", res_valid, 0);
    checkEq("rstBusy", busy, 0);
    checkEq("rstInReady", in_ready, 1);
    checkEq("rstDone", done, 0);
    checkEq("rstAluOp", alu_op, 0);
    checkEq("rstResData", res_data, 0);
    checkEq("rstAluIn1", alu_in1, 0);
    checkEq("rstErrSticky", err_sticky, 0);
    checkEq("rstErrCount", err_count, 0);
  endtask

  // Runs one operand set; stallOp/abortOp of 8 mean "none".
  task automatic runSet(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input int stallOp, input int stallCyc, input int abortOp,
                        input bit holdValid, input bit preAccepted);
    logic [32:0] exp;
    int n;
    if (!preAccepted) begin
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      checkEq("readyBeforeAccept", in_ready, 1);
      in_a = a; in_b = b; in_ci = ci; in_valid = 1'b1;
      @(posedge clk); #1;
      if (!holdValid) in_valid = 1'b0;
    end
    checkEq("busyAfterAccept", busy, 1);
    checkEq("inReadyLowAfterAccept", in_ready, 0);
    for (int op = 0; op < 8; op++) begin
      n = 0;
      while (!res_valid && n < 50) begin
        if (holdValid) begin in_a = $urandom; in_b = $urandom; in_ci = 1'($urandom); end
        @(posedge clk); #1; n++;
      end
      checkEq("latency", n, HOLD);
      exp = aluFn(3'(op), a, b, ci);
      if (faultOn && op == 1) exp[0] = ~exp[0];
      checkEq("resOp", res_op, op);
      checkEq("resData", res_data, exp[31:0]);
      checkEq("resCo", res_co, exp[32]);
      checkEq("aluOp", alu_op, op);
      checkEq("aluIn1", alu_in1, a);
      checkEq("aluIn2", alu_in2, b);
      checkEq("aluCi", alu_ci, ci);
      checkEq("inReadyLowBusy", in_ready, 0);
      got[op] = res_data;
      if (op == abortOp) begin
        #2 rst_n = 1'b0;
        #1 checkResetState();
        #2 rst_n = 1'b1;
        return;
      end
      if (op == stallOp) begin
        res_ready = 1'b0;
        repeat (stallCyc) begin
          @(posedge clk); #1;
          checkEq("stallValid", res_valid, 1);
          checkEq("stallData", res_data, exp[31:0]);
          checkEq("stallAluOp", alu_op, op);
        end
        res_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (op < 7) begin
        checkEq("noEarlyDone", done, 0);
        checkEq("validDropAfterHs", res_valid, 0);
      end else begin
        checkEq("donePulse", done, 1);
        checkEq("idleAfterDone", busy, 0);
        checkEq("readyAfterDone", in_ready, 1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] expTbl [8];
    logic [31:0] a2, b2;
    expTbl[0] = 32'h00F000F0; expTbl[1] = 32'hFFF0FFF0; expTbl[2] = 32'hFF00FF00;
    expTbl[3] = 32'h0F0F0F0F; expTbl[4] = 32'h00E100E0; expTbl[5] = 32'hF0F00000;
    expTbl[6] = 32'h0000F0F0; expTbl[7] = 32'h0000F0F0;

    #1 rst_n = 1'b0;
    #2 checkResetState();
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reference vector with op 2 stalled for 5 cycles
    runSet(32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 2, 5, 8, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) checkEq($sformatf("refVector%0d", i), got[i], expTbl[i]);

    // Carry wrap on ADD
    runSet(32'hFFFFFFFF, 32'h0, 1'b1, 8, 0, 8, 1'b0, 1'b0);
    checkEq("addWrapData", got[4], 32'h0);

    for (int s = 0; s < 6; s++)
      runSet($urandom, $urandom, 1'($urandom), $urandom_range(0, 8), $urandom_range(1, 4),
             8, 1'b0, 1'b0);

    // Reset during op-3 WAIT, then a full set must start at op 0
    runSet($urandom, $urandom, 1'b0, 8, 0, 3, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkEq("inReadyAfterAbort", in_ready, 1);
    runSet($urandom, $urandom, 1'b1, 8, 0, 8, 1'b0, 1'b0);

    // in_valid held across a set, then immediate back-to-back accept
    runSet($urandom, $urandom, 1'b0, 8, 0, 8, 1'b1, 1'b0);
    a2 = $urandom; b2 = $urandom;
    in_a = a2; in_b = b2; in_ci = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    runSet(a2, b2, 1'b1, 8, 0, 8, 1'b0, 1'b1);

    checkEq("errStickyClean", err_sticky, 0);
    checkEq("errCountClean", err_count, 0);
    faultOn = 1'b1;
    runSet($urandom, $urandom, 1'b0, 8, 0, 8, 1'b0, 1'b0);
    faultOn = 1'b0;
`ifdef ALU_SEQ_CHECK_EN
    checkEq("errStickyFault", err_sticky, 1);
    checkEq("errCountFault", err_count, 1);
`else
    checkEq("errStickyFault", err_sticky, 0);
    checkEq("errCountFault", err_count, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
